// File: rtl/data_sram_responder.sv
// Data SRAM responder: accepts load/store requests, writes byte lanes on the
// accepting edge and returns one in-order response per request after a fixed
// latency, with a bounded number of outstanding requests.
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        stall
);

  localparam int unsigned WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned LAST  = LATENCY - 1;

  logic [31:0]           mem_q  [WORDS];
  logic [LATENCY-1:0]    vld_q, vld_d;
  logic [31:0]           word_q [LATENCY];
  logic [31:0]           word_d [LATENCY];
  logic [CNT_W-1:0]      out_q, out_d;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  accept;
  logic                  unused_addr_bits;

  assign idx              = data_sram_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  // Response stage outputs come straight from the last pipeline slot.
  assign data_sram_data_ok = vld_q[LAST];
  assign data_sram_rdata   = word_q[LAST];

  // A slot frees up in the same cycle the oldest response retires.
  assign data_sram_addr_ok = ~stall & ((out_q < CNT_W'(DEPTH)) | data_sram_data_ok);
  assign accept            = data_sram_req & data_sram_addr_ok;

  // Next-state: shift the response pipeline and track outstanding requests.
  always_comb begin
    vld_d = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      word_d[i] = word_q[i];
    end
    out_d = out_q + CNT_W'(accept) - CNT_W'(data_sram_data_ok);

    // Stores answer with a zero word; loads capture the array before any write.
    vld_d[0]  = accept;
    word_d[0] = data_sram_wr ? 32'h0 : mem_q[idx];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      word_d[i] = word_q[i-1];
    end

    // The output word only changes when a real response arrives, so rdata holds.
    if (!vld_d[LAST]) begin
      word_d[LAST] = word_q[LAST];
    end
  end

  // Pipeline and counter registers; in-flight responses are dropped on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      out_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        word_q[i] <= 32'h0;
      end
    end else begin
      vld_q <= vld_d;
      out_q <= out_d;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        word_q[i] <= word_d[i];
      end
    end
  end

  // Byte-strobed array write on the accepting edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          mem_q[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: four instances with different latency/depth
// share one request stream; a queue-based reference model predicts each one.
module tb_data_sram_responder;

  localparam int NI = 4;
  localparam int LAT [NI] = '{1, 2, 3, 3};
  localparam int DEP [NI] = '{2, 2, 1, 2};

  logic          clk = 1'b0;
  logic          reset, req, wr, stall;
  logic [3:0]    wstrb;
  logic [31:0]   addr, wdata;
  logic [NI-1:0] aok, dok;
  logic [31:0]   rd [NI];

  always #5 clk = ~clk;

  data_sram_responder #(.ADDR_WIDTH(14), .LATENCY(1), .DEPTH(2)) u0 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]), .data_sram_rdata(rd[0]),
    .stall(stall));
  data_sram_responder #(.ADDR_WIDTH(14), .LATENCY(2), .DEPTH(2)) u1 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]), .data_sram_rdata(rd[1]),
    .stall(stall));
  data_sram_responder #(.ADDR_WIDTH(14), .LATENCY(3), .DEPTH(1)) u2 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]), .data_sram_rdata(rd[2]),
    .stall(stall));
  data_sram_responder #(.ADDR_WIDTH(14), .LATENCY(3), .DEPTH(2)) u3 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[3]), .data_sram_data_ok(dok[3]), .data_sram_rdata(rd[3]),
    .stall(stall));

  // Reference model: per-instance word memory plus a queue of (due cycle, data).
  int            cyc;
  logic [31:0]   mmem [int];
  int            q_due [NI][$];
  logic [31:0]   q_dat [NI][$];
  logic [NI-1:0] e_aok, e_dok;
  logic [31:0]   e_rd [NI];
  logic [31:0]   held [NI];
  int            vectors, miscompares;

  function automatic int mkey(input int k, input logic [31:0] a);
    return k * 65536 + int'(a[15:2]);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      q_due[k].delete();
      q_dat[k].delete();
      held[k] = 32'h0;
    end
  endtask

  // Wait for the sampling point and form this cycle's expected outputs.
  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      e_dok[k] = 1'b0;
      if (q_due[k].size() != 0) e_dok[k] = (q_due[k][0] == cyc);
      e_rd[k]  = e_dok[k] ? q_dat[k][0] : held[k];
      e_aok[k] = !stall && ((q_due[k].size() < DEP[k]) || e_dok[k]);
    end
  endtask

  // Advance one clock edge and apply accepts/retirements to the model.
  task automatic tick();
    logic        r, w, rst;
    logic [3:0]  s;
    logic [31:0] a, d, cur;
    int          key;
    r = req; w = wr; rst = reset; s = wstrb; a = addr; d = wdata;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (e_dok[k]) begin
          held[k] = q_dat[k].pop_front();
          void'(q_due[k].pop_front());
        end
        if (r && e_aok[k]) begin
          key = mkey(k, a);
          cur = (mmem.exists(key) != 0) ? mmem[key] : 32'h0;
          if (w) begin
            for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
            mmem[key] = cur;
            q_dat[k].push_back(32'h0);
          end else begin
            q_dat[k].push_back(cur);
          end
          q_due[k].push_back(cyc + LAT[k] - 1);
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, input logic st);
    req = r; wr = w; addr = a; wdata = d; wstrb = s; stall = st;
  endtask

  // Full-word stores held long enough that every instance accepts each one.
  task automatic preload(input logic [31:0] base, input int n, input logic rnd);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? $urandom() : 32'(i + 1);
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 1'b1, base + 32'(4 * i), d, 4'hF, 1'b0);
        sample();
        tick();
      end
    end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    reset = 1'b1;
    model_clear();
    sample();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (aok[k] !== 1'b0 || dok[k] !== 1'b0 || rd[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_stalled u%0d: got aok=%b dok=%b rdata=%h, expected 0 0 00000000", k, aok[k], dok[k], rd[k]);
      end
    end
    stall = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (aok[k] !== 1'b1 || dok[k] !== 1'b0 || rd[k] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_state u%0d: got aok=%b dok=%b rdata=%h, expected 1 0 00000000", k, aok[k], dok[k], rd[k]);
      end
    end
    tick();
    reset = 1'b0;
    sample();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
        miscompares++;
        $display("FAIL post_reset u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                 k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
      end
    end
    tick();
  endtask

  task automatic test_word_rw();
    for (int r = 0; r < 8; r++) begin
      if (r == 0)      drive(1'b1, 1'b1, 32'h1C00, 32'h12345678, 4'hF, 1'b0);
      else if (r == 1) drive(1'b1, 1'b0, 32'h1C00, 32'h0, 4'h0, 1'b0);
      else             drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL word_rw u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      if (r == 1 || r == 2) begin
        vectors++;
        if (dok[0] !== 1'b1 || rd[0] !== ((r == 1) ? 32'h0 : 32'h12345678)) begin
          miscompares++;
          $display("FAIL word_rw_lat1 r=%0d: got dok=%b rdata=%h, expected dok=1 rdata=%h",
                   r, dok[0], rd[0], (r == 1) ? 32'h0 : 32'h12345678);
        end
      end
      tick();
    end
  endtask

  task automatic test_byte_strobe();
    for (int r = 0; r < 18; r++) begin
      if (r < 4)       drive(1'b1, 1'b1, 32'h40, 32'hAABBCCDD, 4'hF, 1'b0);
      else if (r < 8)  drive(1'b1, 1'b1, 32'h41, 32'h00001100, 4'b0010, 1'b0);
      else if (r < 12) drive(1'b1, 1'b0, 32'h43, 32'h0, 4'h0, 1'b0);
      else             drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL byte_strobe u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      tick();
    end
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (rd[k] !== 32'hAABB11DD) begin
        miscompares++;
        $display("FAIL byte_strobe_word u%0d: got rdata=%h, expected aabb11dd", k, rd[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ok;
    preload(32'h200, 4, 1'b0);
    for (int r = 0; r < 10; r++) begin
      if (r < 4) drive(1'b1, 1'b0, 32'h200 + 32'(4 * r), 32'h0, 4'h0, 1'b0);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL back_to_back u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      exp_ok = (r >= 2 && r <= 5);
      vectors++;
      if ((r < 4 && aok[1] !== 1'b1) || dok[1] !== exp_ok || (exp_ok && rd[1] !== 32'(r - 1))) begin
        miscompares++;
        $display("FAIL back_to_back_l2 r=%0d: got aok=%b dok=%b rdata=%h, expected aok=1 dok=%b rdata=%0d",
                 r, aok[1], dok[1], rd[1], exp_ok, r - 1);
      end
      tick();
    end
  endtask

  task automatic test_depth_limit();
    int accepts;
    accepts = 0;
    for (int r = 0; r < 15; r++) begin
      if (r < 9) drive(1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 1'b0);
      else       drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL depth_limit u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      if (r < 9) begin
        vectors++;
        if (aok[2] !== ((r % 3) == 0)) begin
          miscompares++;
          $display("FAIL depth_limit_aok r=%0d: got aok=%b, expected %b", r, aok[2], (r % 3) == 0);
        end
        if (aok[2] === 1'b1) accepts++;
      end
      tick();
    end
    vectors++;
    if (accepts != 3) begin
      miscompares++;
      $display("FAIL depth_limit_count: got %0d accepts in 9 cycles, expected 3", accepts);
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < 13; r++) begin
      if (r == 0)     drive(1'b1, 1'b0, 32'h208, 32'h0, 4'h0, 1'b0);
      else if (r < 6) drive(1'b1, 1'b0, 32'h20C, 32'h0, 4'h0, 1'b1);
      else if (r == 6) drive(1'b1, 1'b0, 32'h20C, 32'h0, 4'h0, 1'b0);
      else            drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL stall u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      if (r >= 1 && r <= 6) begin
        vectors++;
        if (aok !== ((r == 6) ? 4'b1111 : 4'b0000)) begin
          miscompares++;
          $display("FAIL stall_aok r=%0d: got aok=%b, expected %b", r, aok, (r == 6) ? 4'b1111 : 4'b0000);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 17; r++) begin
      reset = (r == 2);
      if (r == 0)      drive(1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
      else if (r == 1) drive(1'b1, 1'b0, 32'h204, 32'h0, 4'h0, 1'b0);
      else if (r >= 7 && r < 11) drive(1'b1, 1'b0, 32'h208, 32'h0, 4'h0, 1'b0);
      else             drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      if (r == 2) model_clear();
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL reset_mid u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      if (r >= 2 && r <= 6) begin
        vectors++;
        if (dok[3] !== 1'b0 || rd[3] !== 32'h0 || aok[3] !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_mid_l3 r=%0d: got aok=%b dok=%b rdata=%h, expected 1 0 00000000", r, aok[3], dok[3], rd[3]);
        end
      end
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (rd[k] !== 32'h3) begin
        miscompares++;
        $display("FAIL reset_mid_array u%0d: got rdata=%h, expected 00000003", k, rd[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    preload(32'h300, 8, 1'b1);
    for (int r = 0; r < 310; r++) begin
      a = $urandom();
      a[15:5] = 11'h018;
      if (r < 300)
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a, $urandom(),
              4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0);
      else
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      sample();
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (aok[k] !== e_aok[k] || dok[k] !== e_dok[k] || rd[k] !== e_rd[k]) begin
          miscompares++;
          $display("FAIL random u%0d cyc=%0d: got aok=%b dok=%b rdata=%h, expected aok=%b dok=%b rdata=%h",
                   k, cyc, aok[k], dok[k], rd[k], e_aok[k], e_dok[k], e_rd[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    reset       = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    test_reset();
    test_word_rw();
    test_byte_strobe();
    test_back_to_back();
    test_depth_limit();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the pipeline's data SRAM interface: accepts load/store requests issued by the execute stage and returns the full 32-bit read word that the memory stage uses for byte/halfword lane selection and sign extension. It models a pipelined synchronous data RAM with a fixed response latency, a bounded number of outstanding requests, byte-strobe writes and an externally driven stall input. It sits in the SoC wrapper between the CPU core and the data RAM array, and doubles as the data-memory model in the core-level testbench.

## Interface
Parameters:
- ADDR_WIDTH, 14, word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 1, cycles from request acceptance to data_ok; legal range 1..8.
- DEPTH, 2, maximum outstanding (accepted, not yet answered) requests; legal range 1..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_wstrb  in  4  byte write enables for stores; bit i writes wdata[8i+7:8i].
- data_sram_addr  in  32  byte address; bits [ADDR_WIDTH+1:2] index the array, all other bits ignored.
- data_sram_wdata  in  32  store data, already lane-aligned by the initiator.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
- data_sram_data_ok  out  1  one-cycle response pulse, one per accepted request, in order.
- data_sram_rdata  out  32  full read word; valid when data_ok is high.
- stall  in  1  forces addr_ok low (backpressure injection).

## Operation
- Acceptance: a request is accepted on a rising edge where req & addr_ok = 1.
- addr_ok = ~stall & (outstanding < DEPTH | data_ok). It must not depend on req, so no combinational loop forms with the initiator.
- Store on accept: for each set wstrb bit, the byte is written to word addr[ADDR_WIDTH+1:2] at the accepting edge.
  - wstrb = 0 is legal; the array is unchanged, and the store still produces a data_ok.
- Load on accept: the addressed word is read at the accepting edge and carried through a LATENCY-deep response pipeline.
  - A load accepted on the edge after a store to the same word returns the stored bytes.
  - Within one edge, accesses are ordered by acceptance, so RAW ordering is exact.
- Response pipeline: a shift register of LATENCY slots, each holding {valid, is_store, word}. An accepted request enters slot 0; the last slot drives data_ok and rdata.
- Stores return data_ok with rdata = 0.
- rdata holds its last driven value between data_ok pulses.
- outstanding counter, 0..DEPTH:
  - +1 on accept.
  - −1 on data_ok.
  - Unchanged when both occur in the same cycle.
- No misalignment checking; the core raises ADEM before issuing. addr[1:0] is ignored for reads.
- Reset (asynchronous, any time, including mid-transaction):
  - All pipeline valid bits cleared, outstanding = 0, data_ok = 0, rdata = 0.
  - In-flight responses are discarded, not replayed.
  - Array contents are not reset.
  - addr_ok = ~stall immediately after reset.

## Timing
- Accept at edge T: data_ok is high for exactly the cycle following edge T+LATENCY−1. For LATENCY=1, data_ok is high in the cycle after the accept edge.
- Throughput: one request per cycle when DEPTH ≥ LATENCY.
  - With DEPTH < LATENCY, addr_ok drops once DEPTH requests are outstanding.
  - addr_ok re-asserts in the cycle where the oldest response's data_ok is high (same-cycle replace).
- stall takes effect combinationally in the same cycle. In-flight responses still complete on schedule.
- Reset values of outputs: addr_ok = ~stall, data_ok = 0, rdata = 32'h0.

## Test plan
- Reset then word store/load (LATENCY=1):
  - Store 0x12345678 to 0x1C00 with wstrb=4'hF, then load 0x1C00.
  - Required: one data_ok per request; load rdata = 0x12345678 one cycle after its accept.
- Byte strobes:
  - Store 0xAABBCCDD to word 0x40 with wstrb=4'hF.
  - Then store 0x00001100 to 0x41 with wstrb=4'b0010.
  - Then load 0x43.
  - Required: rdata = 0xAABB11DD (full word; the address low bits are ignored).
- Back-to-back pipelined loads (LATENCY=2, DEPTH=2): 4 consecutive loads to words holding 1, 2, 3, 4.
  - Required: addr_ok stays high every cycle.
  - Required: data_ok on 4 consecutive cycles starting 2 cycles after the first accept; rdata 1, 2, 3, 4 in order.
- Depth limit (LATENCY=3, DEPTH=1): req held high.
  - Required: accepts exactly every 3rd cycle; outstanding never exceeds 1.
  - Required: addr_ok is high in each data_ok cycle.
- Stall: stall high for 5 cycles with req high.
  - Required: no accepts, no data_ok beyond in-flight ones.
  - Required: the first accept occurs in the cycle stall drops.
- Reset mid-operation (LATENCY=3): accept 2 loads, then assert reset for 1 cycle before either responds.
  - Required: data_ok stays 0, rdata = 0, addr_ok high after release.
  - Required: a subsequent load still returns prior array contents.
